parity_frame_serializer: RTL
============================

# parity_frame_serializer

Parallel-to-serial framer that feeds the serial parity-tracking FSM stage. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB first, one bit per bit period. It then optionally appends an even-parity bit. Per-bit strobe and last-bit markers let the downstream Mealy stage advance exactly once per bit.

## Interface
- DATA_W, default 8: word width in bits, must be ≥ 2.
- BAUD_DIV, default 1: clock cycles per serial bit, must be ≥ 1.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_data  in  DATA_W  parallel word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  high for every cycle of every bit period in a frame.
- ser_stb  out  1  one-cycle pulse on the last cycle of each bit period; this is the downstream sample/advance enable.
- frame_last  out  1  high for the whole period of the final bit of a frame.

## Operation
- States:
  - IDLE: in_ready=1.
  - DATA: shifting DATA_W bits.
  - PAR: parity bit. Present only with SER_PARITY_EN.
- Accept condition: in_valid & in_ready in IDLE. On that edge:
  - capture in_data into the shift register;
  - compute parity = ^in_data, so total ones including the parity bit are even;
  - clear bit_cnt and div_cnt;
  - go to DATA.
- DATA:
  - ser_out = shreg[0], ser_valid=1.
  - div_cnt counts 0..BAUD_DIV-1. ser_stb=1 when div_cnt==BAUD_DIV-1.
  - On that cycle, shift right, bit_cnt+1, and div_cnt wraps to 0.
  - After bit DATA_W-1, go to PAR (macro on) or IDLE (macro off).
- PAR: ser_out=parity for one bit period with the same strobe rule, then go to IDLE.
- frame_last: high during the PAR period (macro on) or the bit DATA_W-1 period (macro off).
- Counters:
  - bit_cnt width is $clog2(DATA_W+1).
  - div_cnt width is max(1, $clog2(BAUD_DIV)).
  - With BAUD_DIV=1, div_cnt stays 0 and ser_stb=1 on every frame cycle.
- in_valid outside IDLE is ignored. in_data need not be held after acceptance.
- in_valid dropping mid-frame has no effect; the frame completes.
- Reset mid-frame: the frame is aborted with no partial completion. Reset value of every output holds immediately:
  - state=IDLE;
  - ser_out=0, ser_valid=0, ser_stb=0, frame_last=0;
  - in_ready=0 while reset is high.

## Timing
- ser_out, ser_valid, ser_stb and frame_last are registered (flop outputs).
- in_ready is decoded from the state register and gated low by reset.
- Latency: first data bit on ser_out in the cycle after the accept edge.
- Frame occupancy: (DATA_W + P) × BAUD_DIV cycles, where P=1 with the macro and P=0 without.
- in_ready returns high the cycle after the final ser_stb.
- Back-to-back rate with in_valid held high is one word per (DATA_W + P) × BAUD_DIV + 1 cycles. The single IDLE cycle between frames is mandatory, and ser_valid=0 in it.
- ser_stb and frame_last both assert on the last cycle of the final bit.

## Configuration
- SER_PARITY_EN defined:
  - PAR state present;
  - even-parity bit appended after the data bits;
  - frame = DATA_W+1 bits.
- SER_PARITY_EN undefined:
  - no PAR state and no parity register;
  - frame = DATA_W data bits only;
  - frame_last on bit DATA_W-1.

## Test plan
- SER_PARITY_EN on, DATA_W=8, BAUD_DIV=1, accept 0xA5:
  - ser_out sequence 1,0,1,0,0,1,0,1 then parity 0 over 9 cycles;
  - ser_stb=1 on all 9 cycles;
  - frame_last only on cycle 9;
  - in_ready=1 on cycle 10.
- Same config, accept 0x07: data bits 1,1,1,0,0,0,0,0 then parity bit 1.
- BAUD_DIV=3, accept 0x01:
  - each bit held for 3 cycles;
  - ser_stb only on the 3rd cycle of each bit (9 pulses);
  - frame occupies 27 cycles.
- in_valid held high with words 0x11 and 0x22, BAUD_DIV=1:
  - second accept exactly 10 cycles after the first;
  - ser_valid=0 in the single gap cycle.
- Reset asserted during the data bit-3 period of 0xFF:
  - all outputs go 0 immediately;
  - in_ready=1 the first cycle after release;
  - a new 0x3C frame starts cleanly with bit0=0.
- SER_PARITY_EN undefined, 0xA5:
  - 8 bits only;
  - frame_last on bit 7;
  - in_ready=1 on cycle 9.

Source files
------------

// File: rtl/parity_frame_serializer_if.sv
// Handshake and serial-stream bundle for parity_frame_serializer.
// The master drives words in and observes the serial stream; the slave is the serializer.
interface parity_frame_serializer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_stb;
  logic              frame_last;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_stb, frame_last
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_stb, frame_last
  );
endinterface

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial framer: LSB-first data bits, optional even-parity bit.
// Define SER_PARITY_EN to append the parity bit (frame = DATA_W+1 bits).
module parity_frame_serializer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BAUD_DIV = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  parity_frame_serializer_if.slave  bus
);

  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_shreg, w_shreg_d;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_d;
  logic [DIV_W-1:0]  r_div_cnt, w_div_cnt_d;
`ifdef SER_PARITY_EN
  logic              r_parity, w_parity_d;
`endif

  logic r_ser_out, r_ser_valid, r_ser_stb, r_frame_last;
  logic w_ser_out_d, w_ser_valid_d, w_ser_stb_d, w_frame_last_d;
  logic w_bit_stb;

  assign w_bit_stb = (r_div_cnt == DIV_LAST);

  always_comb begin
    w_state_d   = r_state;
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    w_div_cnt_d = r_div_cnt;
`ifdef SER_PARITY_EN
    w_parity_d  = r_parity;
`endif
    case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_state_d   = StData;
          w_shreg_d   = bus.in_data;
          w_bit_cnt_d = '0;
          w_div_cnt_d = '0;
`ifdef SER_PARITY_EN
          w_parity_d  = ^bus.in_data;
`endif
        end
      end
      StData: begin
        if (w_bit_stb) begin
          w_div_cnt_d = '0;
          w_shreg_d   = r_shreg >> 1;
          w_bit_cnt_d = r_bit_cnt + 1'b1;
          if (r_bit_cnt == BIT_LAST) begin
`ifdef SER_PARITY_EN
            w_state_d = StPar;
`else
            w_state_d = StIdle;
`endif
          end
        end else begin
          w_div_cnt_d = r_div_cnt + 1'b1;
        end
      end
`ifdef SER_PARITY_EN
      StPar: begin
        if (w_bit_stb) begin
          w_div_cnt_d = '0;
          w_state_d   = StIdle;
        end else begin
          w_div_cnt_d = r_div_cnt + 1'b1;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so the flops present them in the matching cycle.
  always_comb begin
    w_ser_valid_d = (w_state_d != StIdle);
    w_ser_stb_d   = w_ser_valid_d && (w_div_cnt_d == DIV_LAST);
`ifdef SER_PARITY_EN
    w_ser_out_d    = (w_state_d == StPar) ? w_parity_d : (w_shreg_d[0] & w_ser_valid_d);
    w_frame_last_d = (w_state_d == StPar);
`else
    w_ser_out_d    = w_shreg_d[0] & w_ser_valid_d;
    w_frame_last_d = (w_state_d == StData) && (w_bit_cnt_d == BIT_LAST);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
`ifdef SER_PARITY_EN
      r_parity     <= 1'b0;
`endif
      r_ser_out    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_ser_stb    <= 1'b0;
      r_frame_last <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_shreg      <= w_shreg_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_div_cnt    <= w_div_cnt_d;
`ifdef SER_PARITY_EN
      r_parity     <= w_parity_d;
`endif
      r_ser_out    <= w_ser_out_d;
      r_ser_valid  <= w_ser_valid_d;
      r_ser_stb    <= w_ser_stb_d;
      r_frame_last <= w_frame_last_d;
    end
  end

  assign bus.in_ready   = (r_state == StIdle) & ~reset;
  assign bus.ser_out    = r_ser_out;
  assign bus.ser_valid  = r_ser_valid;
  assign bus.ser_stb    = r_ser_stb;
  assign bus.frame_last = r_frame_last;

endmodule
